// File: rtl/memctrl_arbiter_if.sv
// Bundle of the two master request ports and the MEMCTRL strobe bus.
// The arbiter connects through the slave modport; the system side uses master.
interface memctrl_arbiter_if;
  logic        m0_req;
  logic        m0_we;
  logic [15:0] m0_addr;
  logic [7:0]  m0_wdata;
  logic        m0_ack;
  logic [7:0]  m0_rdata;

  logic        m1_req;
  logic        m1_we;
  logic [15:0] m1_addr;
  logic [7:0]  m1_wdata;
  logic        m1_ack;
  logic [7:0]  m1_rdata;

  logic [15:0] mem_addr;
  logic        mem_ce;
  logic        mem_csb;
  logic        mem_web;
  logic        mem_oeb;
  logic [7:0]  mem_idata;
  logic [7:0]  mem_odata;

  logic        busy;
  logic        gnt;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    input  mem_odata,
    output m0_ack, m0_rdata, m1_ack, m1_rdata,
    output mem_addr, mem_ce, mem_csb, mem_web, mem_oeb, mem_idata,
    output busy, gnt
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    output mem_odata,
    input  m0_ack, m0_rdata, m1_ack, m1_rdata,
    input  mem_addr, mem_ce, mem_csb, mem_web, mem_oeb, mem_idata,
    input  busy, gnt
  );
endinterface

// File: rtl/memctrl_arbiter.sv
// Round-robin two-master arbiter that sequences single-byte accesses onto the
// MEMCTRL bus as STROBE -> (WAIT x RD_LAT for reads) -> RECOV; all outputs registered.
module memctrl_arbiter #(
  parameter int unsigned RD_LAT = 1
) (
  input logic              clk_i,
  input logic              rstn_i,
  memctrl_arbiter_if.slave bus
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_STROBE = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;
  localparam logic [1:0] ST_RECOV  = 2'd3;

  localparam logic [1:0] WAIT_LAST = 2'(RD_LAT - 1);

  if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
    $error("memctrl_arbiter: RD_LAT must be in 1..4");
  end

  logic [1:0]       req;
  logic [1:0]       we_in;
  logic [1:0][15:0] addr_in;
  logic [1:0][7:0]  wdata_in;

  assign req      = {bus.m1_req, bus.m0_req};
  assign we_in    = {bus.m1_we, bus.m0_we};
  assign addr_in  = {bus.m1_addr, bus.m0_addr};
  assign wdata_in = {bus.m1_wdata, bus.m0_wdata};

  logic [1:0]      state_q, state_d;
  logic            last_q, last_d;
  logic            gnt_q, gnt_d;
  logic            we_q, we_d;
  logic [15:0]     addr_q, addr_d;
  logic [1:0]      cnt_q, cnt_d;
  logic            ce_q, ce_d;
  logic            csb_q, csb_d;
  logic            web_q, web_d;
  logic            oeb_q, oeb_d;
  logic [7:0]      idata_q, idata_d;
  logic [1:0]      ack_q, ack_d;
  logic [1:0][7:0] rdata_q, rdata_d;
  logic            busy_q, busy_d;

  // Under contention the master not granted last time wins; otherwise the sole requester.
  logic winner;
  assign winner = (req == 2'b11) ? ~last_q : req[1];

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    ce_d    = 1'b0;
    csb_d   = 1'b1;
    web_d   = 1'b1;
    oeb_d   = 1'b1;
    idata_d = 8'h00;
    ack_d   = 2'b00;
    rdata_d = rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          gnt_d   = winner;
          last_d  = winner;
          we_d    = we_in[winner];
          addr_d  = addr_in[winner];
          ce_d    = 1'b1;
          csb_d   = 1'b0;
          web_d   = ~we_in[winner];
          oeb_d   = we_in[winner];
          idata_d = we_in[winner] ? wdata_in[winner] : 8'h00;
          state_d = ST_STROBE;
        end
      end
      ST_STROBE: begin
        if (we_q) begin
          ack_d[gnt_q] = 1'b1;
          state_d      = ST_RECOV;
        end else begin
          cnt_d   = WAIT_LAST;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // The counter reaching zero marks the last WAIT cycle: its closing edge samples MEMCTRL.
        if (cnt_q == 2'd0) begin
          rdata_d[gnt_q] = bus.mem_odata;
          ack_d[gnt_q]   = 1'b1;
          state_d        = ST_RECOV;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b1;
      gnt_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 16'h0000;
      cnt_q   <= 2'd0;
      ce_q    <= 1'b0;
      csb_q   <= 1'b1;
      web_q   <= 1'b1;
      oeb_q   <= 1'b1;
      idata_q <= 8'h00;
      ack_q   <= 2'b00;
      rdata_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      ce_q    <= ce_d;
      csb_q   <= csb_d;
      web_q   <= web_d;
      oeb_q   <= oeb_d;
      idata_q <= idata_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
      busy_q  <= busy_d;
    end
  end

  // The latched access address doubles as MEM_ADDR, so it holds between strobes.
  assign bus.mem_addr  = addr_q;
  assign bus.mem_ce    = ce_q;
  assign bus.mem_csb   = csb_q;
  assign bus.mem_web   = web_q;
  assign bus.mem_oeb   = oeb_q;
  assign bus.mem_idata = idata_q;
  assign bus.m0_ack    = ack_q[0];
  assign bus.m1_ack    = ack_q[1];
  assign bus.m0_rdata  = rdata_q[0];
  assign bus.m1_rdata  = rdata_q[1];
  assign bus.busy      = busy_q;
  assign bus.gnt       = gnt_q;

endmodule

// File: tb/tb_memctrl_arbiter.sv
// Scoreboard bench for memctrl_arbiter: drivers queue expected accesses, a monitor
// checks every ACK against a byte-memory reference, and a MEMCTRL model checks the strobe bus.
module tb_memctrl_arbiter;
  localparam int RD_LAT = 3;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  memctrl_arbiter_if bus ();

  memctrl_arbiter #(.RD_LAT(RD_LAT)) u_dut (
    .clk_i  (clk),
    .rstn_i (rstn),
    .bus    (bus)
  );

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;
    int          cyc;
  } exp_t;

  exp_t       exp_q [2][$];
  int         ack_order [$];
  logic [7:0] ref_mem [65536];
  logic [7:0] mem_arr [65536];
  logic [7:0] rd_hold [2];
  int         waits [2];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic get_ack(input int m);
    return (m == 0) ? bus.m0_ack : bus.m1_ack;
  endfunction

  function automatic logic [7:0] get_rdata(input int m);
    return (m == 0) ? bus.m0_rdata : bus.m1_rdata;
  endfunction

  function automatic logic [31:0] out_vec();
    return {bus.mem_addr, bus.mem_idata, bus.mem_ce, bus.mem_csb, bus.mem_web, bus.mem_oeb,
            bus.m0_ack, bus.m1_ack, bus.busy, bus.gnt};
  endfunction

  task automatic issue(input int m, input logic we, input logic [15:0] a, input logic [7:0] d);
    exp_t e;
    e.we = we; e.addr = a; e.wdata = d; e.cyc = cyc;
    exp_q[m].push_back(e);
    if (m == 0) begin
      bus.m0_we = we; bus.m0_addr = a; bus.m0_wdata = d; bus.m0_req = 1'b1;
    end else begin
      bus.m1_we = we; bus.m1_addr = a; bus.m1_wdata = d; bus.m1_req = 1'b1;
    end
  endtask

  task automatic drop(input int m);
    if (m == 0) bus.m0_req = 1'b0;
    else        bus.m1_req = 1'b0;
  endtask

  task automatic wait_ack(input int m, output bit ok, output int t);
    ok = 1'b0;
    t  = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (get_ack(m)) begin
        ok = 1'b1;
        t  = cyc;
        break;
      end
    end
    chk($sformatf("ack_seen_m%0d", m), 32'(ok), 32'd1);
  endtask

  task automatic do_access(input int m, input logic we, input logic [15:0] a, input logic [7:0] d);
    bit ok;
    int t;
    issue(m, we, a, d);
    wait_ack(m, ok, t);
    drop(m);
    @(negedge clk);
  endtask

  // Back-to-back requester: with a zero gap the REQ stays high across the ACK cycle.
  task automatic drive(input int m, input int n, input bit rnd);
    for (int i = 0; i < n; i++) begin
      logic        we;
      logic [15:0] a;
      logic [7:0]  d;
      bit          ok;
      int          t;
      int          gap;
      if (rnd) begin
        we = 1'($urandom_range(0, 1));
        a  = {2'($urandom_range(0, 3)), 11'd0, 3'($urandom_range(0, 3))};
        d  = 8'($urandom);
      end else begin
        we = 1'b1;
        a  = (m == 0) ? 16'(i) : 16'(16'hC000 + i);
        d  = 8'(8'h50 + 16 * m + i);
      end
      issue(m, we, a, d);
      wait_ack(m, ok, t);
      if (!ok) begin
        drop(m);
        return;
      end
      gap = rnd ? int'($urandom_range(0, 2)) : 0;
      if (i == n - 1 || gap > 0) begin
        drop(m);
        repeat (gap) @(negedge clk);
      end
    end
  endtask

  // Scoreboard monitor: one line per completed access.
  task automatic on_ack(input int m);
    int   o;
    exp_t e;
    o = 1 - m;
    if (exp_q[m].size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_ack: m%0d pulsed ACK, required no ACK (nothing pending)", m);
      return;
    end
    e = exp_q[m].pop_front();
    $display("[cyc %0d] ack m%0d %s addr=%04h wdata=%02h rdata=%02h", cyc, m,
             e.we ? "WR" : "RD", e.addr, e.wdata, get_rdata(m));
    chk("ack_gnt", 32'(bus.gnt), 32'(m));
    chk("ack_busy", 32'(bus.busy), 32'd1);
    if (e.we) begin
      ref_mem[e.addr] = e.wdata;
      chk("wr_rdata_hold", 32'(get_rdata(m)), 32'(rd_hold[m]));
    end else begin
      chk("rd_data", 32'(get_rdata(m)), 32'(ref_mem[e.addr]));
      rd_hold[m] = ref_mem[e.addr];
    end
    chk("other_rdata_hold", 32'(get_rdata(o)), 32'(rd_hold[o]));
    ack_order.push_back(m);
    waits[m] = 0;
    if (exp_q[o].size() > 0 && exp_q[o][0].cyc < cyc) begin
      waits[o]++;
      chk("rr_wait_bound", 32'(waits[o] <= 1), 32'd1);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rstn) begin
        for (int m = 0; m < 2; m++) begin
          if (get_ack(m)) on_ack(m);
        end
      end
    end
  end

  // MEMCTRL model: stores writes, returns read data only in the sample cycle, checks strobes.
  initial begin
    int          cnt;
    int          last_sc;
    int          g;
    logic        prev_ce;
    logic        last_rd;
    logic [15:0] rd_addr;
    cnt = 0; last_sc = -100; prev_ce = 1'b0; last_rd = 1'b0; rd_addr = 16'h0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        cnt = 0; last_sc = -100; prev_ce = 1'b0;
        bus.mem_odata = 8'($urandom);
        continue;
      end
      if (bus.mem_ce) begin
        chk("strobe_one_cycle", 32'(prev_ce), 32'd0);
        chk("strobe_spacing", 32'((cyc - last_sc) >= (last_rd ? 3 + RD_LAT : 3)), 32'd1);
        chk("strobe_csb", 32'(bus.mem_csb), 32'd0);
        chk("strobe_oeb", 32'(bus.mem_oeb), 32'(!bus.mem_web));
        g = int'(bus.gnt);
        if (exp_q[g].size() > 0) begin
          chk("strobe_addr", 32'(bus.mem_addr), 32'(exp_q[g][0].addr));
          chk("strobe_web", 32'(bus.mem_web), 32'(!exp_q[g][0].we));
        end
        if (!bus.mem_web) begin
          if (exp_q[g].size() > 0) chk("strobe_idata", 32'(bus.mem_idata), 32'(exp_q[g][0].wdata));
          mem_arr[bus.mem_addr] = bus.mem_idata;
        end else begin
          chk("rd_strobe_idata", 32'(bus.mem_idata), 32'd0);
          cnt     = RD_LAT;
          rd_addr = bus.mem_addr;
        end
        last_sc = cyc;
        last_rd = bus.mem_web;
        bus.mem_odata = 8'($urandom);
      end else begin
        chk("idle_strobes", 32'({bus.mem_csb, bus.mem_web, bus.mem_oeb, bus.mem_idata}), 32'h700);
        if (cnt > 0) begin
          cnt--;
          bus.mem_odata = (cnt == 0) ? mem_arr[rd_addr] : 8'($urandom);
        end else begin
          bus.mem_odata = 8'($urandom);
        end
      end
      prev_ce = bus.mem_ce;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within the time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int         c;
    int         t;
    bit         ok;
    logic [7:0] bank_val [4];
    bank_val = '{8'h11, 8'h22, 8'h33, 8'h44};

    bus.m0_req = 1'b0; bus.m0_we = 1'b0; bus.m0_addr = 16'h0; bus.m0_wdata = 8'h0;
    bus.m1_req = 1'b0; bus.m1_we = 1'b0; bus.m1_addr = 16'h0; bus.m1_wdata = 8'h0;
    bus.mem_odata = 8'h0;
    for (int i = 0; i < 65536; i++) begin
      ref_mem[i] = 8'h00;
      mem_arr[i] = 8'h00;
    end
    rd_hold[0] = 8'h00; rd_hold[1] = 8'h00;
    waits[0] = 0; waits[1] = 0;

    rstn = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", out_vec(), 32'h0000_0070);
    chk("reset_rdata", 32'({bus.m0_rdata, bus.m1_rdata}), 32'd0);
    rstn = 1'b1;
    @(negedge clk);

    // Single M0 write, cycle by cycle.
    issue(0, 1'b1, 16'h4000, 8'hA5);
    @(negedge clk);
    chk("wr_strobe_ctl", 32'({bus.mem_ce, bus.mem_csb, bus.mem_web, bus.mem_oeb}), 32'b1001);
    chk("wr_strobe_addr", 32'(bus.mem_addr), 32'h4000);
    chk("wr_strobe_idata", 32'(bus.mem_idata), 32'hA5);
    chk("wr_strobe_busy_gnt", 32'({bus.busy, bus.gnt}), 32'b10);
    @(negedge clk);
    chk("wr_ack", 32'({bus.m0_ack, bus.m1_ack}), 32'b10);
    chk("wr_recov_bus", 32'({bus.mem_ce, bus.mem_csb, bus.mem_web, bus.mem_oeb, bus.mem_idata}), 32'h700);
    drop(0);
    @(negedge clk);
    chk("idle_busy", 32'(bus.busy), 32'd0);
    chk("addr_holds", 32'(bus.mem_addr), 32'h4000);

    // M1 write then read back with the read-latency timing.
    do_access(1, 1'b1, 16'h8000, 8'h3C);
    issue(1, 1'b0, 16'h8000, 8'h00);
    c = cyc;
    @(negedge clk);
    chk("rd_strobe_ctl", 32'({bus.mem_ce, bus.mem_csb, bus.mem_web, bus.mem_oeb}), 32'b1010);
    wait_ack(1, ok, t);
    chk("rd_ack_latency", 32'(t - c), 32'(2 + RD_LAT));
    chk("rd_m1_rdata", 32'(bus.m1_rdata), 32'h3C);
    chk("rd_m0_rdata", 32'(bus.m0_rdata), 32'h00);
    drop(1);
    @(negedge clk);

    // Contention with both masters kept requesting: grants alternate starting with M0.
    ack_order.delete();
    fork
      drive(0, 3, 1'b0);
      drive(1, 3, 1'b0);
    join
    @(negedge clk);
    chk("rr_count", 32'(ack_order.size()), 32'd6);
    for (int i = 0; i < ack_order.size() && i < 6; i++) begin
      chk($sformatf("rr_order_%0d", i), 32'(ack_order[i]), 32'(i % 2));
    end

    // One byte per bank, read back by the other master.
    for (int b = 0; b < 4; b++) do_access(0, 1'b1, {2'(b), 14'h0}, bank_val[b]);
    for (int b = 0; b < 4; b++) begin
      issue(1, 1'b0, {2'(b), 14'h0}, 8'h00);
      wait_ack(1, ok, t);
      chk($sformatf("bank_rd_%0d", b), 32'(bus.m1_rdata), 32'(bank_val[b]));
      drop(1);
      @(negedge clk);
    end

    // Reset in the middle of a read WAIT.
    issue(1, 1'b0, 16'h4000, 8'h00);
    repeat (2) @(negedge clk);
    chk("in_wait", 32'({bus.busy, bus.mem_ce}), 32'b10);
    rstn = 1'b0;
    bus.m1_req = 1'b0;
    exp_q[0].delete(); exp_q[1].delete();
    rd_hold[0] = 8'h00; rd_hold[1] = 8'h00;
    waits[0] = 0; waits[1] = 0;
    #1;
    chk("midreset_outputs", out_vec(), 32'h0000_0070);
    chk("midreset_rdata", 32'({bus.m0_rdata, bus.m1_rdata}), 32'd0);
    repeat (RD_LAT + 2) begin
      @(negedge clk);
      chk("midreset_no_ack", 32'({bus.m0_ack, bus.m1_ack, bus.m1_rdata}), 32'd0);
    end
    rstn = 1'b1;
    @(negedge clk);
    issue(1, 1'b1, 16'h0040, 8'h77);
    c = cyc;
    @(negedge clk);
    chk("post_reset_strobe_gnt", 32'({bus.mem_ce, bus.gnt}), 32'b11);
    wait_ack(1, ok, t);
    chk("post_reset_wr_latency", 32'(t - c), 32'd2);
    drop(1);
    @(negedge clk);
    do_access(1, 1'b0, 16'h0040, 8'h00);

    // Randomised traffic from both masters.
    fork
      drive(0, 25, 1'b1);
      drive(1, 25, 1'b1);
    join
    repeat (RD_LAT + 4) @(negedge clk);
    chk("queues_drained", 32'(exp_q[0].size() + exp_q[1].size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/memctrl_arbiter.md
# memctrl_arbiter

Two-port arbiter and strobe sequencer in front of `MEMCTRL`. It accepts single-byte read/write requests from two masters over a level req / pulse ack handshake and grants them round-robin. It drives the `MEMCTRL` bus with the one-cycle chip-enable strobe followed by a recovery cycle, and returns read data to the granted master. It sits between the system-side masters (CPU, DMA) and the 4-bank `MEMCTRL`; the bank is selected by `ADDR[15:14]`.

## Interface
- `RD_LAT`, 1: cycles from the read strobe cycle to the `MEM_ODATA` sample edge; legal range 1..4.

- `CLK` in 1: single clock; all logic is rising-edge.
- `RSTN` in 1: reset, asynchronous, active-low.
- `M0_REQ` / `M1_REQ` in 1: access request, level; held high until ack.
- `M0_WE` / `M1_WE` in 1: 1 = write, 0 = read; stable while REQ is high.
- `M0_ADDR` / `M1_ADDR` in 16: byte address; stable while REQ is high.
- `M0_WDATA` / `M1_WDATA` in 8: write data; stable while REQ is high.
- `M0_ACK` / `M1_ACK` out 1: one-cycle completion pulse.
- `M0_RDATA` / `M1_RDATA` out 8: read data; valid from the ACK cycle; held until that master's next read completes.
- `MEM_ADDR` out 16: address to `MEMCTRL`.
- `MEM_CE` out 1: chip enable, active-high.
- `MEM_CSB` out 1: chip select, active-low.
- `MEM_WEB` out 1: write enable, active-low.
- `MEM_OEB` out 1: output enable, active-low.
- `MEM_IDATA` out 8: write data to `MEMCTRL`.
- `MEM_ODATA` in 8: read data from `MEMCTRL`.
- `BUSY` out 1: high in every state except IDLE.
- `GNT` out 1: index of the current or most recently granted master.

## Operation
States:
- **IDLE**: if any REQ is high, latch the winner's WE, ADDR and WDATA, set `GNT` and `last`, then go to STROBE.
- **STROBE** (1 cycle): `MEM_CE`=1, `MEM_CSB`=0, `MEM_WEB`=~WE, `MEM_OEB`=WE, `MEM_ADDR`=latched address, `MEM_IDATA`=WDATA for writes, else 0. Go to WAIT if reading, RECOV if writing.
- **WAIT** (RD_LAT cycles, 2-bit counter): strobes idle (`MEM_CE`=0, `MEM_CSB`=`MEM_WEB`=`MEM_OEB`=1), `MEM_OEB` included. On the edge ending the last WAIT cycle, sample `MEM_ODATA` into the granted master's RDATA register. Then go to RECOV.
- **RECOV** (1 cycle): strobes idle; pulse the granted master's ACK; go to IDLE.

Arbitration:
- Round-robin. If both REQs are high in IDLE, grant the master not granted last time; otherwise grant the sole requester.
- `last` resets to 1, so M0 wins the first contention.
- REQ is sampled only in IDLE. Requests arriving while BUSY wait as pending levels.
- A REQ still high in the ACK cycle counts as a new request, evaluated in the following IDLE cycle. Under contention it loses to the other master.
- Worst-case wait: one full access by the other master.

Other rules:
- `MEM_ADDR` holds its last value outside STROBE.
- `MEM_IDATA` is 0 outside write STROBE.
- REQ dropped before ACK is a protocol violation; the access still completes and ACK still pulses.
- The non-granted master's RDATA is never modified.

## Timing
- Reset values:
  - `MEM_ADDR`=0, `MEM_IDATA`=0, `MEM_CE`=0, `MEM_CSB`=1, `MEM_WEB`=1, `MEM_OEB`=1.
  - Both ACK=0, both RDATA=0, `BUSY`=0, `GNT`=0.
  - State IDLE, `last`=1.
- Reset asserted mid-access: all outputs return to reset values immediately (asynchronous), with no ACK and no RDATA update. The first cycle after deassertion is IDLE.
- Write, REQ first seen high at edge n: STROBE in cycle n+1, ACK in cycle n+2. Next STROBE no earlier than cycle n+4.
- Read: STROBE in cycle n+1, WAIT in cycles n+2..n+1+RD_LAT, ACK and RDATA valid in cycle n+2+RD_LAT.
- Minimum spacing between STROBE cycles: 3 cycles for writes, 3+RD_LAT cycles for reads. The bus therefore always sees at least one idle cycle between strobes.
- All outputs are registered; none depends combinationally on REQ or `MEM_ODATA`.

## Test plan
- Reset, then M0 writes 0xA5 to 0x4000 with REQ high at edge 10 -> cycle 11: CE=1, CSB=0, WEB=0, OEB=1, ADDR=0x4000, IDATA=0xA5; cycle 12: M0_ACK=1, strobes idle, IDATA=0.
- M1 writes 0x3C to 0x8000, then M1 reads 0x8000 with RD_LAT=1 -> read STROBE has WEB=1, OEB=0; M1_ACK two cycles after the STROBE with M1_RDATA=0x3C; M0_RDATA stays 0.
- M0 and M1 both request writes in the same IDLE cycle, to 0x0000 and 0xC000 -> M0 served first, then M1. With both then kept requesting, grants strictly alternate M0, M1, M0, M1 across 4 accesses.
- Write 0x11/0x22/0x33/0x44 to 0x0000/0x4000/0x8000/0xC000, then read each back -> RDATA values match, one per ACK. Every STROBE is exactly one cycle, with at least one idle cycle between strobes.
- Assert RSTN low during a read WAIT cycle -> all outputs immediately take reset values, no ACK is issued, RDATA stays 0. After release, a new M1 request is granted from IDLE.
- RD_LAT=3, read 0x4000 -> ACK five cycles after the IDLE sample edge (n+5). RDATA equals the `MEM_ODATA` present at the end of the third WAIT cycle.
